// File: rtl/fifo_pkg.sv
// Shared constants and pointer helpers for the single-clock FIFO.
// Pointers carry one extra wrap bit above the memory address bits.
package fifo_pkg;

    localparam int unsigned FIFO_WIDTH = 8;
    localparam int unsigned FIFO_DEPTH = 16;

    // Increment a ptr_w-bit pointer, wrapping back to zero past its top value.
    function automatic logic [31:0] ptr_inc(input logic [31:0] ptr, input int unsigned ptr_w);
        logic [31:0] mask;
        mask = (32'd1 << ptr_w) - 32'd1;
        return (ptr + 32'd1) & mask;
    endfunction

    function automatic logic ptr_empty(input logic [31:0] wptr, input logic [31:0] rptr);
        return (wptr == rptr);
    endfunction

    // Full: address bits match while the wrap bits differ.
    function automatic logic ptr_full(input logic [31:0] wptr, input logic [31:0] rptr,
                                      input int unsigned addr_w);
        return ((wptr ^ rptr) == (32'd1 << addr_w));
    endfunction

endpackage

// File: rtl/fifo_mem.sv
// Simple dual-port storage: synchronous write port, registered read port with enable.
// The array itself is never reset; only the read register is.
module fifo_mem
    import fifo_pkg::*;
#(
    parameter int unsigned WIDTH = FIFO_WIDTH,
    parameter int unsigned DEPTH = FIFO_DEPTH
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     i_wr_en,
    input  logic [$clog2(DEPTH)-1:0] i_wr_addr,
    input  logic [WIDTH-1:0]         i_wr_data,
    input  logic                     i_rd_en,
    input  logic [$clog2(DEPTH)-1:0] i_rd_addr,
    output logic [WIDTH-1:0]         o_rd_data
);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [WIDTH-1:0] r_rd_data;

    // Storage write port.
    always_ff @(posedge clk) begin
        if (i_wr_en) begin
            r_mem[i_wr_addr] <= i_wr_data;
        end
    end

    // Read register: loads on an accepted read, otherwise holds.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_rd_data <= {WIDTH{1'b0}};
        end else if (i_rd_en) begin
            r_rd_data <= r_mem[i_rd_addr];
        end
    end

    assign o_rd_data = r_rd_data;

endmodule

// File: rtl/fifo_async.sv
// Single-clock FIFO: wrap-bit pointers, flags decoded from registered pointers only.
// Writes when full and reads when empty are dropped.
module fifo_async
    import fifo_pkg::*;
#(
    parameter int unsigned WIDTH = FIFO_WIDTH,
    parameter int unsigned DEPTH = FIFO_DEPTH
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             wr_en,
    input  logic [WIDTH-1:0] wr_data,
    output logic             full,
    input  logic             rd_en,
    output logic [WIDTH-1:0] rd_data,
    output logic             empty
);

    localparam int unsigned ADDR_W = $clog2(DEPTH);
    localparam int unsigned PTR_W  = ADDR_W + 1;

    logic [PTR_W-1:0] r_wptr;
    logic [PTR_W-1:0] r_rptr;
    logic [PTR_W-1:0] w_wptr_nxt;
    logic [PTR_W-1:0] w_rptr_nxt;
    logic             w_full;
    logic             w_empty;
    logic             w_wr_acc;
    logic             w_rd_acc;

    assign w_empty    = ptr_empty(32'(r_wptr), 32'(r_rptr));
    assign w_full     = ptr_full(32'(r_wptr), 32'(r_rptr), ADDR_W);
    // Gating with rst_n keeps a request coincident with reset from touching memory.
    assign w_wr_acc   = wr_en & ~w_full & rst_n;
    assign w_rd_acc   = rd_en & ~w_empty & rst_n;
    assign w_wptr_nxt = PTR_W'(ptr_inc(32'(r_wptr), PTR_W));
    assign w_rptr_nxt = PTR_W'(ptr_inc(32'(r_rptr), PTR_W));

    // Write pointer advances on each accepted write.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wptr <= {PTR_W{1'b0}};
        end else if (w_wr_acc) begin
            r_wptr <= w_wptr_nxt;
        end
    end

    // Read pointer advances on each accepted read.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_rptr <= {PTR_W{1'b0}};
        end else if (w_rd_acc) begin
            r_rptr <= w_rptr_nxt;
        end
    end

    fifo_mem #(
        .WIDTH (WIDTH),
        .DEPTH (DEPTH)
    ) u_mem (
        .clk       (clk),
        .rst_n     (rst_n),
        .i_wr_en   (w_wr_acc),
        .i_wr_addr (r_wptr[ADDR_W-1:0]),
        .i_wr_data (wr_data),
        .i_rd_en   (w_rd_acc),
        .i_rd_addr (r_rptr[ADDR_W-1:0]),
        .o_rd_data (rd_data)
    );

    assign full  = w_full;
    assign empty = w_empty;

endmodule

// File: tb/tb_fifo_async.sv
// Scoreboard bench for fifo_async: a queue-based reference FIFO predicts flags and
// read data; a separate monitor compares DUT outputs on every falling edge.
module tb_fifo_async;

    localparam int WIDTH = 8;
    localparam int DEPTH = 16;

    logic             clk     = 1'b0;
    logic             rst_n   = 1'b0;
    logic             wr_en   = 1'b0;
    logic             rd_en   = 1'b0;
    logic [WIDTH-1:0] wr_data = 8'h00;
    logic [WIDTH-1:0] rd_data;
    logic             full;
    logic             empty;

    int total = 0;
    int bad   = 0;

    logic [WIDTH-1:0] mq[$];
    logic [WIDTH-1:0] exp_q[$];
    bit               rd_evt  = 1'b0;
    logic [WIDTH-1:0] last_rd = 8'h00;

    always #5 clk = ~clk;

    fifo_async #(
        .WIDTH (WIDTH),
        .DEPTH (DEPTH)
    ) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .wr_en   (wr_en),
        .wr_data (wr_data),
        .full    (full),
        .rd_en   (rd_en),
        .rd_data (rd_data),
        .empty   (empty)
    );

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h at %0t", nm, act, exp, $time);
        end
    endtask

    // Reference model: plain queue of stored words; accepted reads push the expected word.
    initial begin
        forever begin
            @(posedge clk or negedge rst_n);
            if (!rst_n) begin
                mq.delete();
                exp_q.delete();
                rd_evt  = 1'b0;
                last_rd = 8'h00;
            end else begin
                rd_evt = rd_en && (mq.size() != 0);
                if (rd_evt) exp_q.push_back(mq[0]);
                if (wr_en && (mq.size() < DEPTH)) mq.push_back(wr_data);
                if (rd_evt) mq.delete(0);
            end
        end
    end

    // Monitor: compares flags every cycle and read data whenever a read was accepted.
    initial begin
        logic [WIDTH-1:0] e;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                chk("rst_empty", 32'(empty), 32'd1);
                chk("rst_full", 32'(full), 32'd0);
                chk("rst_rd_data", 32'(rd_data), 32'd0);
            end else begin
                chk("empty", 32'(empty), 32'(mq.size() == 0));
                chk("full", 32'(full), 32'(mq.size() == DEPTH));
                if (rd_evt) begin
                    e = exp_q.pop_front();
                    chk("rd_order", 32'(rd_data), 32'(e));
                    last_rd = e;
                end else begin
                    chk("rd_hold", 32'(rd_data), 32'(last_rd));
                end
            end
        end
    end

    task automatic cyc(input logic w, input logic [WIDTH-1:0] d, input logic r);
        @(negedge clk);
        #1;
        wr_en   = w;
        wr_data = d;
        rd_en   = r;
    endtask

    task automatic drain();
        int n;
        n = 0;
        while (mq.size() != 0 && n < 4 * DEPTH) begin
            cyc(1'b0, 8'h00, 1'b1);
            n++;
        end
        cyc(1'b0, 8'h00, 1'b0);
    endtask

    initial begin
        #500us;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int pw;
        int pr;
        // Reset held, then released away from the rising edge.
        rst_n = 1'b0;
        #200;
        @(negedge clk);
        #1;
        rst_n = 1'b1;

        // Fill, overflow attempt, drain plus one extra read.
        for (int i = 0; i < DEPTH; i++) cyc(1'b1, 8'(i), 1'b0);
        cyc(1'b1, 8'hAA, 1'b0);
        for (int i = 0; i < DEPTH; i++) cyc(1'b0, 8'h00, 1'b1);
        cyc(1'b0, 8'h00, 1'b1);
        cyc(1'b0, 8'h00, 1'b0);
        cyc(1'b0, 8'h00, 1'b0);

        // Wrap with concurrent read and write.
        for (int i = 0; i < 10; i++) cyc(1'b1, 8'(8'h10 + i), 1'b0);
        for (int i = 0; i < 10; i++) cyc(1'b0, 8'h00, 1'b1);
        for (int i = 0; i < 16; i++) cyc(1'b1, 8'(8'h20 + i), (i >= 8));
        drain();

        // Reset pulse between edges after five writes.
        for (int i = 0; i < 5; i++) cyc(1'b1, 8'(8'h50 + i), 1'b0);
        @(posedge clk);
        #2;
        wr_en = 1'b0;
        rst_n = 1'b0;
        #1;
        chk("midrst_empty", 32'(empty), 32'd1);
        chk("midrst_full", 32'(full), 32'd0);
        chk("midrst_rd_data", 32'(rd_data), 32'd0);
        #1;
        rst_n = 1'b1;
        for (int i = 0; i < 3; i++) cyc(1'b0, 8'h00, 1'b1);
        cyc(1'b0, 8'h00, 1'b0);

        // Randomized traffic in write-heavy, read-heavy and balanced phases.
        for (int ph = 0; ph < 3; ph++) begin
            pw = (ph == 0) ? 75 : ((ph == 1) ? 30 : 50);
            pr = (ph == 0) ? 30 : ((ph == 1) ? 75 : 50);
            for (int i = 0; i < 800; i++) begin
                cyc(($urandom_range(0, 99) < pw), 8'($urandom), ($urandom_range(0, 99) < pr));
            end
        end
        drain();
        repeat (2) @(negedge clk);
        chk("scoreboard_drained", 32'(exp_q.size()), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/fifo_async.md
Name: fifo_async

Overview:
Parameterised first-in first-out data buffer with `full` and `empty` status flags, sitting between a producer and a consumer in the datapath. The block runs on one clock, and both the write side and the read side are synchronous to it. Storage is a circular buffer addressed by wrapping write and read pointers. Writes to a full buffer and reads from an empty buffer are dropped silently.

Parameters:
- WIDTH, 8, data word width in bits (>=1).
- DEPTH, 16, number of storage entries; power of two, >=2.
- ADDR_W, $clog2(DEPTH), derived localparam; not overridable.

Ports:
- clk  input  1  the single clock; everything is sampled on its rising edge.
- rst_n  input  1  asynchronous active-low reset; release is synchronous to clk.
- wr_en  input  1  write request.
- wr_data  input  WIDTH  write data, sampled when wr_en=1.
- full  output  1  buffer holds DEPTH entries.
- rd_en  input  1  read request.
- rd_data  output  WIDTH  registered read data.
- empty  output  1  buffer holds 0 entries.

Interface decision: one clock; reset is asynchronous and active-low.

Behaviour:
- Reset (rst_n=0, takes effect immediately):
  - write pointer and read pointer = 0
  - empty=1, full=0, rd_data=0
  - memory contents are not reset.
- Pointers are ADDR_W+1 bits wide. Bits [ADDR_W-1:0] index memory; the MSB is a wrap bit.
- empty when the two pointers are equal. full when the low ADDR_W bits are equal and the wrap bits differ.
- Flags are decoded from registered pointers only; there is no combinational path from wr_en or rd_en to the flags.
- Write accepted = wr_en & ~full.
  - On acceptance, mem[wptr] <= wr_data and wptr increments on that edge.
  - full updates in the same cycle the pointer changes, i.e. it is visible after the accepting edge.
- Read accepted = rd_en & ~empty.
  - On acceptance, rd_data <= mem[rptr] and rptr increments.
  - Latency is one clock: data is valid after the accepting edge.
  - rd_data holds its last value when no read is accepted.
- Write while full: ignored. No pointer change, no memory change, even if rd_en=1 in the same cycle.
- Read while empty: ignored. rd_data holds, even if wr_en=1 in the same cycle. The write still completes.
- Simultaneous accepted read and write (neither full nor empty): both occur; occupancy is unchanged, so the flags are unchanged.
- Ordering is strictly FIFO. Pointer wrap from DEPTH-1 to 0 toggles the wrap bit; no data loss across the wrap.
- Full after exactly DEPTH accepted writes from empty. Empty after exactly DEPTH accepted reads from full.
- Reset asserted mid-operation:
  - all stored data is discarded logically (empty=1, full=0)
  - rd_data returns to 0
  - any in-flight request on that edge is dropped.
- No X on outputs after reset, regardless of memory contents.

Decomposition:
- Package fifo_pkg holds:
  - the default WIDTH and DEPTH constants
  - a function for pointer increment with wrap
  - the full/empty compare helpers.
- One natural sub-module: fifo_mem, a WIDTH x DEPTH simple dual-port array with a synchronous write port and a registered read port with enable.
- Pointer and flag logic live in fifo_async itself.

Test Plan:
1. Reset: hold rst_n=0 for 200 ns, then release. Required: empty=1, full=0, rd_data=0 throughout reset and on the first clock after release.
2. Fill: wr_en=1 with data 0,1,2,...,15 on consecutive clocks. Required: full=1 after the 16th accepting edge, not before; empty=0 after the first.
3. Overflow: with the buffer full, one clock of wr_en=1, wr_data=8'hAA. Required: ignored, full stays 1, and 8'hAA never appears on rd_data.
4. Drain: rd_en=1 until empty. Required: rd_data sequence 0..15, each value valid one clock after its accepting edge; empty=1 after the 16th read; a further read leaves rd_data=15.
5. Wrap and concurrency:
   - Write 10 words, read 10 words, then write 16 words (0x20..0x2F) while reading concurrently from the 9th write onward.
   - Required: in-order data, no spurious full or empty, correct pointer wrap.
6. Reset mid-operation: after 5 writes, pulse rst_n=0 between clock edges. Required: immediate empty=1, full=0, rd_data=0; a subsequent read with no writes is ignored.
